addsub_chunked_seq: RTL and testbench
=====================================

Name: addsub_chunked_seq

Overview:
- Parametrised, multi-cycle add/subtract unit. Processes the operands CHUNK bits per cycle, LSB first, with the carry held in a register.
- Produces a result plus carry, overflow and zero flags. Optional saturation on signed overflow.
- Sits between the operand-fetch stage and the ALU result mux. Trades latency for a narrow carry chain.
- Uses a valid/ready handshake on both its input side and its output side.

Parameters:
- WIDTH, 16: operand and result width in bits; WIDTH >= 2.
- CHUNK, 4: bits processed per cycle. WIDTH % CHUNK must be 0. CHUNK == WIDTH gives a single compute cycle.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and control are valid.
- in_ready  out  1  unit can accept an operation.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  0 = a+b+cin; 1 = a-b-cin (cin acts as borrow-in).
- cin  in  1  carry-in (add) or borrow-in (sub).
- sat  in  1  1 = saturate the result on signed overflow.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum or difference, saturated if enabled.
- cout  out  1  final carry; for sub, 1 = no borrow.
- overflow  out  1  signed overflow of the unsaturated result.
- zero  out  1  result (after saturation) == 0.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE; out_valid=0; result=0; cout=0; overflow=0; zero=0; carry register 0; chunk counter 0.
- in_ready = (state==IDLE). It is combinational from state and therefore 1 in the cycle after reset.
- States:
  - IDLE: on in_valid && in_ready at an edge, latch a, bx = b ^ {WIDTH{sub}}, sat, and carry = cin ^ sub. Clear the counter, go to BUSY. If in_valid is low, stay in IDLE.
  - BUSY: each edge processes chunk k = counter: {c, r[k]} = a[k] + bx[k] + carry. Write r[k] into the result register, carry <= c, counter++. The edge that processes chunk N-1 (N = WIDTH/CHUNK) goes to DONE and registers the flags.
  - DONE: out_valid=1. On out_valid && out_ready at an edge, go to IDLE and set out_valid=0. in_ready stays 0 throughout DONE; no simultaneous accept.
- Latency: the accept edge is T. out_valid is high in the cycle following edge T+N. Minimum occupancy is N+2 cycles per operation.
- Flags, computed on the final chunk:
  - cout = final carry.
  - overflow = (a[W-1]==bx[W-1]) && (r[W-1]!=a[W-1]).
  - If sat && overflow: result = a[W-1] ? {1,0..0} (min) : {0,1..1} (max). overflow still reads 1.
  - zero is computed on the final (possibly saturated) result.
- Output stability: result and flags are registered and stay stable while out_valid is high. a, b, sub, cin and sat are sampled only at accept; later changes are ignored.
- Intermediate result bits may change during BUSY; the consumer uses them only when out_valid=1.
- Reset mid-operation, in BUSY or DONE: the operation is aborted, out_valid drops to 0, and the unit returns to IDLE. No partial result is presented.
- in_valid while not in IDLE: ignored, not queued.
- Wrap-around: results are modulo 2^WIDTH when sat=0; the carry out of bit W-1 goes only to cout.

Test Plan (WIDTH=16, CHUNK=4):
1. Add, a=0x1234, b=0x0FFF, sub=0, cin=0 -> result 0x2233, cout=0, overflow=0, zero=0. out_valid rises in the cycle after the 4th post-accept edge; in_ready=0 from accept until return to IDLE.
2. Sub, a=0x8000, b=0x0001, cin=0:
   - sat=0 -> result 0x7FFF, cout=1, overflow=1.
   - sat=1 -> result 0x8000, overflow=1.
3. Add, a=0x7FFF, b=0x0001:
   - sat=0 -> result 0x8000, overflow=1.
   - sat=1 -> result 0x7FFF.
   - Also a=0xFFFF, b=0x0001 -> result 0x0000, cout=1, zero=1, overflow=0 (carry through all chunks).
4. Sub, a=0x0005, b=0x0005, cin=0 -> 0x0000, zero=1, cout=1. Borrow case: a=0x0000, b=0x0000, cin=1, sub=1 -> 0xFFFF, cout=0, zero=0.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE; drive in_valid=1 with a=0x1111, b=0x2222 -> result/flags unchanged, in_ready=0, new operands not taken. Release out_ready -> IDLE and in_ready=1 next cycle.
6. Reset mid-BUSY: assert rst after 2 chunks -> out_valid stays 0 and in_ready=1 after the reset edge. A following add 0x0001+0x0002 -> 0x0003 with correct flags.

Source files
------------

// File: rtl/addsub_chunked_seq_if.sv
// Operand/result bundle for the chunked add/subtract unit.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. A source holds valid and its payload steady until
// that edge. A sink may drive ready from its own state only, never from valid.
// On this unit in_ready depends on state alone. out_valid stays high and
// result/flags stay frozen until out_ready is seen.
interface addsub_chunked_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, sub, cin, sat, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  // The arithmetic unit itself.
  modport slave (
    input  in_valid, a, b, sub, cin, sat, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/addsub_chunked_seq.sv
// Multi-cycle add/subtract unit. It processes CHUNK bits per cycle, LSB first,
// and keeps the inter-chunk carry in a register. Subtraction is done as
// a + ~b + ~borrow_in, so cout = 1 means "no borrow". Saturation on signed
// overflow is optional, and the overflow flag always reports the raw result.
module addsub_chunked_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  addsub_chunked_seq_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, bx_q, res_q;
  logic             sat_q, carry_q, cout_q, ovf_q, zero_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, last_chunk;
  int               base;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_raw, res_final;
  logic             ovf_raw;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;

  assign accept     = bus.in_valid && (state_q == IDLE);
  assign last_chunk = (state_q == BUSY) && (cnt_q == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Back-to-back accept from DONE is not allowed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One chunk of the adder, plus the flag and saturation logic. The flag and
  // saturation outputs are only meaningful on the final chunk.
  always_comb begin
    base      = int'(cnt_q) * CHUNK;
    chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, bx_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    res_raw   = res_q;
    res_raw[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    ovf_raw   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (res_raw[WIDTH-1] != a_q[WIDTH-1]);
    res_final = res_raw;
    if (sat_q && ovf_raw) res_final = a_q[WIDTH-1] ? SMIN : SMAX;
  end

  // Operand capture at accept, chunk accumulation in BUSY, flags on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      bx_q    <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      bx_q    <= bus.b ^ {WIDTH{bus.sub}};
      sat_q   <= bus.sat;
      carry_q <= bus.cin ^ bus.sub;
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      carry_q <= chunk_sum[CHUNK];
      if (last_chunk) begin
        res_q  <= res_final;
        cnt_q  <= '0;
        cout_q <= chunk_sum[CHUNK];
        ovf_q  <= ovf_raw;
        zero_q <= (res_final == '0);
      end else begin
        res_q  <= res_raw;
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_addsub_chunked_seq.sv
// Self-checking bench for addsub_chunked_seq (WIDTH=16, CHUNK=4).
// The reference model works on exact integer arithmetic: it computes the
// unsigned and signed true values and derives the result and flags from them.
module tb_addsub_chunked_seq;
  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;

  // Expected outputs, packed as {zero, overflow, cout, result}.
  logic [W+2:0] exp_q[$];

  addsub_chunked_seq_if #(.WIDTH(W)) bus ();

  addsub_chunked_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] pack(input logic z, input logic o, input logic c,
                                        input logic [W-1:0] r);
    return {z, o, c, r};
  endfunction

  // Reference model from exact arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin, input logic sat);
    longint     ua, ub, sa, sb, ci, eu, es;
    logic       c, o;
    logic [W-1:0] r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = longint'(cin);
    if (!sub) begin
      eu = ua + ub + ci;
      es = sa + sb + ci;
      c  = (eu > 65535);
    end else begin
      eu = ua - ub - ci;
      es = sa - sb - ci;
      c  = (eu >= 0);
    end
    r = eu[W-1:0];
    o = (es > 32767) || (es < -32768);
    if (sat && o) r = (es > 0) ? 16'h7FFF : 16'h8000;
    return pack(r == '0, o, c, r);
  endfunction

  // Scoreboard compare: checks every cycle the outputs are valid.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got result 0x%0h with no expected entry", bus.result);
      end else begin
        check("result_flags", {bus.zero, bus.overflow, bus.cout, bus.result}, exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: one full operation with latency, ready and backpressure checks.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, input logic sat, input int hold);
    @(negedge clk);
    check("accept_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.sat = sat;
    exp_q.push_back(model(a, b, sub, cin, sat));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    bus.sub = 1'($urandom); bus.cin = 1'($urandom); bus.sat = 1'($urandom);
    check("busy_in_ready", bus.in_ready, 0);
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      check("latency_out_valid", bus.out_valid, (k == N) ? 1 : 0);
      check("busy_done_in_ready", bus.in_ready, 0);
    end
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'h1111; bus.b = 16'h2222;
      @(posedge clk); #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
  endtask

  // Accept an operation, then reset after two chunks have been processed.
  task automatic abort_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.sub = 1'b0; bus.cin = 1'b0; bus.sat = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_mid_out_valid", bus.out_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    exp_q.delete();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] edge_vals[4];
    tests = 0;
    fails = 0;
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'h7FFF;
    edge_vals[2] = 16'h8000; edge_vals[3] = 16'hFFFF;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0; bus.sat = 1'b0;

    // Hand-computed values that pin the model.
    check("model_add",      model(16'h1234, 16'h0FFF, 0, 0, 0), pack(0, 0, 0, 16'h2233));
    check("model_sub_ovf",  model(16'h8000, 16'h0001, 1, 0, 0), pack(0, 1, 1, 16'h7FFF));
    check("model_sub_sat",  model(16'h8000, 16'h0001, 1, 0, 1), pack(0, 1, 1, 16'h8000));
    check("model_add_ovf",  model(16'h7FFF, 16'h0001, 0, 0, 0), pack(0, 1, 0, 16'h8000));
    check("model_add_sat",  model(16'h7FFF, 16'h0001, 0, 0, 1), pack(0, 1, 0, 16'h7FFF));
    check("model_add_wrap", model(16'hFFFF, 16'h0001, 0, 0, 0), pack(1, 0, 1, 16'h0000));
    check("model_sub_zero", model(16'h0005, 16'h0005, 1, 0, 0), pack(1, 0, 1, 16'h0000));
    check("model_borrow",   model(16'h0000, 16'h0000, 1, 1, 0), pack(0, 0, 0, 16'hFFFF));

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready",  bus.in_ready, 1);
    check("reset_result",    bus.result, 0);
    check("reset_flags",     {bus.cout, bus.overflow, bus.zero}, 0);
    check("reset_state",     dbg_state, 0);

    // Directed cases, the backpressure case holds out_ready low for 3 cycles.
    do_op(16'h1234, 16'h0FFF, 0, 0, 0, 0);
    do_op(16'h8000, 16'h0001, 1, 0, 0, 1);
    do_op(16'h8000, 16'h0001, 1, 0, 1, 0);
    do_op(16'h7FFF, 16'h0001, 0, 0, 0, 0);
    do_op(16'h7FFF, 16'h0001, 0, 0, 1, 2);
    do_op(16'hFFFF, 16'h0001, 0, 0, 0, 0);
    do_op(16'h0005, 16'h0005, 1, 0, 0, 0);
    do_op(16'h0000, 16'h0000, 1, 1, 0, 0);
    do_op(16'h1234, 16'h4321, 0, 1, 0, 3);

    // Reset in the middle of BUSY, then a clean operation.
    abort_op(16'hABCD, 16'h1357);
    do_op(16'h0001, 16'h0002, 0, 0, 0, 0);

    // Randomised operations, with operands biased toward signed boundaries.
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      do_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
